// File: rtl/mem_access_ctrl_if.sv
// MEM-stage sequencer bus: EX/MEM instruction view, data-memory handshake,
// and the stall/bubble/error controls fed back to the pipeline.
interface mem_access_ctrl_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned SC_W   = 16;

    logic              exmem_valid;
    logic              exmem_mem_read;
    logic              exmem_mem_write;
    logic [ADDR_W-1:0] exmem_addr;
    logic              mem_done;
    logic              mem_en;
    logic              mem_wr;
    logic              pipe_stall;
    logic              memwb_bubble;
    logic              err_out;
    logic [SC_W-1:0]   stall_cycles;

    modport slave (
        input  exmem_valid, exmem_mem_read, exmem_mem_write, exmem_addr, mem_done,
        output mem_en, mem_wr, pipe_stall, memwb_bubble, err_out, stall_cycles
    );

    modport master (
        output exmem_valid, exmem_mem_read, exmem_mem_write, exmem_addr, mem_done,
        input  mem_en, mem_wr, pipe_stall, memwb_bubble, err_out, stall_cycles
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage access sequencer: issues one memory request per load/store, stalls
// the pipe until completion, and latches a sticky error on bad/timed-out accesses.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   bus
);
    localparam int unsigned WCNT_W = 8;
    localparam int unsigned SC_W   = 16;

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t            state;
    logic [WCNT_W-1:0] wait_cnt;
    logic              err_q;
    logic [SC_W-1:0]   stall_q;

    logic access;
    logic illegal;
    logic mem_en;
    logic mem_wr;
    logic stall;
    logic unused_addr_hi;

    // Upper address bits only matter to the memory; alignment uses bit 0.
    assign unused_addr_hi = ^bus.exmem_addr[15:1];

    always_comb begin
        access  = bus.exmem_valid & (bus.exmem_mem_read | bus.exmem_mem_write);
        illegal = bus.exmem_addr[0] | (bus.exmem_mem_read & bus.exmem_mem_write);
        mem_en  = 1'b0;
        mem_wr  = 1'b0;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    if (!illegal) begin
                        mem_en = 1'b1;
                        mem_wr = bus.exmem_mem_write;
                    end
                end
            end
            WAIT:    stall = ~bus.mem_done;
            ERR:     stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // State, wait counter, sticky error and saturating stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            stall_q  <= '0;
        end else begin
            if (stall && (stall_q != '1)) begin
                stall_q <= stall_q + SC_W'(1);
            end
            case (state)
                IDLE: begin
                    if (access) begin
                        if (illegal) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_done) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                        // This is the TIMEOUT-th cycle without completion.
                        if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_en       = mem_en;
    assign bus.mem_wr       = mem_wr;
    assign bus.pipe_stall   = stall;
    assign bus.memwb_bubble = stall;
    assign bus.err_out      = err_q;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised scoreboard bench for mem_access_ctrl; expected behaviour is derived
// from per-access latency and legality, not from the controller's internals.
module tb_mem_access_ctrl;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          errors = 0;
    int          checks = 0;
    bit          exp_q[$];
    int unsigned model_sc = 0;
    bit          model_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit r, input bit w, input logic [15:0] a, input bit d);
        bus.exmem_valid     = v;
        bus.exmem_mem_read  = r;
        bus.exmem_mem_write = w;
        bus.exmem_addr      = a;
        bus.mem_done        = d;
    endtask

    // Each request strobe must match the oldest issued access.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.mem_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mem_en", 32'(bus.mem_en), 32'd0);
                end else begin
                    bit e;
                    e = exp_q.pop_front();
                    check("mem_wr", 32'(bus.mem_wr), 32'(e));
                end
            end
        end
    end

    // One clock: check stall/bubble/error/counter, then advance the model.
    task automatic tick(input bit exp_stall);
        @(negedge clk);
        check("pipe_stall", 32'(bus.pipe_stall), 32'(exp_stall));
        check("memwb_bubble", 32'(bus.memwb_bubble), 32'(exp_stall));
        check("err_out", 32'(bus.err_out), 32'(model_err));
        check("stall_cycles", 32'(bus.stall_cycles), model_sc);
        if (exp_stall && model_sc < 32'hFFFF) model_sc++;
        @(posedge clk);
        #1;
    endtask

    // lat = cycles from mem_en to mem_done; 0 means memory never answers.
    task automatic do_access(input bit r, input bit w, input logic [15:0] a, input int unsigned lat);
        bit legal;
        legal = !a[0] && !(r && w);
        drive(1'b1, r, w, a, 1'b0);
        if (legal) exp_q.push_back(w);
        tick(1'b1);
        check("issue_count", 32'(exp_q.size()), 32'd0);
        if (!legal) begin
            model_err = 1'b1;
            return;
        end
        if (lat == 0) begin
            for (int k = 1; k <= int'(TO); k++) tick(1'b1);
            model_err = 1'b1;
            return;
        end
        for (int k = 1; k <= int'(lat); k++) begin
            bus.mem_done = (k == int'(lat));
            tick(k != int'(lat));
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic idle_cycle();
        if ($urandom_range(0, 1) == 0)
            drive(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
        else
            drive(1'b1, 1'b0, 1'b0, 16'($urandom), 1'($urandom));
        tick(1'b0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic reset_async();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        check("rst_memwb_bubble", 32'(bus.memwb_bubble), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_err_out", 32'(bus.err_out), 32'd0);
        check("rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);
        model_sc  = 0;
        model_err = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("init_stall_cycles", 32'(bus.stall_cycles), 32'd0);
        check("init_err_out", 32'(bus.err_out), 32'd0);
        rst = 1'b1;

        do_access(1'b1, 1'b0, 16'h0040, 3);
        tick(1'b0);

        do_access(1'b0, 1'b1, 16'h1000, 1);
        do_access(1'b1, 1'b0, 16'h1002, 1);
        tick(1'b0);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end else begin
                bit wr;
                wr = 1'($urandom);
                do_access(!wr, wr, 16'($urandom) & 16'hFFFE, $urandom_range(1, TO));
            end
        end
        tick(1'b0);

        // Reset two cycles into WAIT, then a stray done after release.
        reset_async();
        drive(1'b1, 1'b1, 1'b0, 16'h0080, 1'b0);
        exp_q.push_back(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        reset_async();
        bus.mem_done = 1'b1;
        tick(1'b0);
        bus.mem_done = 1'b0;
        tick(1'b0);
        do_access(1'b1, 1'b0, 16'h0100, 2);
        tick(1'b0);

        // Misaligned load: sticky error, done pulses ignored.
        do_access(1'b1, 1'b0, 16'h0041, 1);
        for (int i = 0; i < 6; i++) begin
            bus.mem_done = 1'(i & 1);
            tick(1'b1);
        end
        reset_async();

        // Timeout after TO WAIT cycles without completion.
        do_access(1'b0, 1'b1, 16'h0200, 0);
        repeat (3) tick(1'b1);
        reset_async();

        // Stall counter saturation while parked in the error state.
        do_access(1'b1, 1'b1, 16'h0010, 0);
        repeat (70000) tick(1'b1);
        @(negedge clk);
        check("stall_saturated", 32'(bus.stall_cycles), 32'hFFFF);
        check("leftover_expected", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
